usb_rx_bitproc: RTL and testbench

- Consumes the synchronized line state plus the mid-bit sample strobe from the sample-position adjuster.
- Per strobe: performs NRZI decode, SYNC detection, bit unstuffing, byte assembly and EOP detection.
- Delivers a byte stream with packet framing and error pulses to the packet decoder.
- Runs entirely in the 4x clock domain; all work is gated by i_sample_en.

---
 rtl/usb_pkg.sv | 32 +++
 rtl/usb_nrzi_dec.sv | 62 ++++++
 rtl/usb_rx_bitproc.sv | 224 ++++++++++++++++++++++
 tb/tb_usb_rx_bitproc.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_pkg
// Description : Shared definitions for the USB receive bit-processing slice.
//               Holds the line-state encodings, the receive FSM state enum
//               and the default SYNC / bit-stuffing constants.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_pkg;

   // Line state as {dp, dn}
   typedef enum logic [1:0] {
      LINE_SE0 = 2'b00,
      LINE_K   = 2'b01,
      LINE_J   = 2'b10,
      LINE_SE1 = 2'b11
   } line_t;

   // Receive FSM states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SYNC  = 3'd1,
      ST_DATA  = 3'd2,
      ST_EOP   = 3'd3,
      ST_ABORT = 3'd4
   } rx_state_t;

   localparam int SYNC_ZEROS_DEF = 5;
   localparam int STUFF_LEN_DEF  = 6;

endpackage
`default_nettype wire

// File: rtl/usb_nrzi_dec.sv
`default_nettype none
// ============================================================================
// Module      : usb_nrzi_dec
// Description : Line-state decode and NRZI bit recovery. Keeps the previous
//               J/K line level and reports, on each sample strobe, the
//               decoded bit and the line classification.
// Revision    : 1.0 - initial release
//
// Ports:
//   i_clk_4x    in   4x bit-rate clock
//   i_rst_n     in   async active-low reset
//   i_sample_en in   mid-bit sample strobe
//   i_dp, i_dn  in   synchronized D+ / D-
//   o_bit       out  decoded NRZI bit (1 = no transition), strobe-qualified
//   o_is_j      out  line is J, strobe-qualified
//   o_is_k      out  line is K, strobe-qualified
//   o_is_se0    out  line is SE0, strobe-qualified
//   o_is_se1    out  line is SE1, strobe-qualified
// ============================================================================
module usb_nrzi_dec
   import usb_pkg::*;
(
   input  logic i_clk_4x,
   input  logic i_rst_n,
   input  logic i_sample_en,
   input  logic i_dp,
   input  logic i_dn,
   output logic o_bit,
   output logic o_is_j,
   output logic o_is_k,
   output logic o_is_se0,
   output logic o_is_se1
);

   line_t w_line;
   line_t r_prev_line;

   assign w_line = line_t'({i_dp, i_dn});

   // Only J/K are ever stored, so a single-ended line never reads as "no
   // transition". SE0 re-arms the reference to J for the idle/next packet.
   always_ff @(posedge i_clk_4x or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prev_line <= LINE_J;
      end else if (i_sample_en) begin
         case (w_line)
            LINE_J,
            LINE_K:   r_prev_line <= w_line;
            LINE_SE0: r_prev_line <= LINE_J;
            default:  r_prev_line <= r_prev_line;
         endcase
      end
   end

   assign o_bit    = i_sample_en && (w_line == r_prev_line);
   assign o_is_j   = i_sample_en && (w_line == LINE_J);
   assign o_is_k   = i_sample_en && (w_line == LINE_K);
   assign o_is_se0 = i_sample_en && (w_line == LINE_SE0);
   assign o_is_se1 = i_sample_en && (w_line == LINE_SE1);

endmodule
`default_nettype wire

// File: rtl/usb_rx_bitproc.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_bitproc
// Description : USB receive bit processor. Per sample strobe it NRZI-decodes
//               the line, detects SYNC, removes stuffed bits, assembles bytes
//               (LSB first) and detects EOP, producing a framed byte stream
//               with error pulses.
// Revision    : 1.0 - initial release
//
// Optional feature macro: USB_RX_ALIGN_CHECK_EN
//   defined   : o_err_align pulses with o_eop when the packet ended on a
//               partial byte
//   undefined : o_err_align is tied to 0
//
// Ports:
//   i_clk_4x    in   4x bit-rate clock (sole clock)
//   i_rst_n     in   async active-low reset
//   i_sample_en in   mid-bit sample strobe
//   i_dp, i_dn  in   synchronized D+ / D-
//   o_data      out  assembled byte, LSB received first
//   o_valid     out  one-cycle pulse, o_data valid
//   o_sop       out  one-cycle pulse, SYNC accepted
//   o_eop       out  one-cycle pulse, EOP completed
//   o_active    out  high from o_sop until o_eop or abort
//   o_err       out  one-cycle pulse, stuff error / SE1 / bad EOP
//   o_err_align out  one-cycle pulse, EOP with partial byte
// ============================================================================
module usb_rx_bitproc
   import usb_pkg::*;
#(
   parameter int SYNC_ZEROS = SYNC_ZEROS_DEF,
   parameter int STUFF_LEN  = STUFF_LEN_DEF
)(
   input  logic       i_clk_4x,
   input  logic       i_rst_n,
   input  logic       i_sample_en,
   input  logic       i_dp,
   input  logic       i_dn,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_sop,
   output logic       o_eop,
   output logic       o_active,
   output logic       o_err,
   output logic       o_err_align
);

   localparam logic [2:0] c_sync_zeros = 3'(SYNC_ZEROS);
   localparam logic [2:0] c_stuff_len  = 3'(STUFF_LEN);

   logic w_bit;
   logic w_is_j;
   logic w_is_k;
   logic w_is_se0;
   logic w_is_se1;
   logic [7:0] w_shift;

   rx_state_t  r_state;
   logic [2:0] r_zeros;
   logic [2:0] r_ones;
   logic [2:0] r_bitcnt;
   logic [7:0] r_shreg;
   logic       r_abort_se0;
   logic [7:0] r_data;
   logic       r_valid;
   logic       r_sop;
   logic       r_eop;
   logic       r_active;
   logic       r_err;

   usb_nrzi_dec u_nrzi (
      .i_clk_4x    (i_clk_4x),
      .i_rst_n     (i_rst_n),
      .i_sample_en (i_sample_en),
      .i_dp        (i_dp),
      .i_dn        (i_dn),
      .o_bit       (w_bit),
      .o_is_j      (w_is_j),
      .o_is_k      (w_is_k),
      .o_is_se0    (w_is_se0),
      .o_is_se1    (w_is_se1)
   );

   // Bits arrive LSB first, so each new bit enters at the MSB
   assign w_shift = {w_bit, r_shreg[7:1]};

`ifdef USB_RX_ALIGN_CHECK_EN
   logic r_err_align;
`endif

   always_ff @(posedge i_clk_4x or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_zeros     <= 3'd0;
         r_ones      <= 3'd0;
         r_bitcnt    <= 3'd0;
         r_shreg     <= 8'd0;
         r_abort_se0 <= 1'b0;
         r_data      <= 8'd0;
         r_valid     <= 1'b0;
         r_sop       <= 1'b0;
         r_eop       <= 1'b0;
         r_active    <= 1'b0;
         r_err       <= 1'b0;
`ifdef USB_RX_ALIGN_CHECK_EN
         r_err_align <= 1'b0;
`endif
      end else begin
         r_valid <= 1'b0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
         r_err   <= 1'b0;
`ifdef USB_RX_ALIGN_CHECK_EN
         r_err_align <= 1'b0;
`endif
         if (i_sample_en) begin
            case (r_state)
               ST_IDLE: begin
                  // First K of SYNC is itself the first transition (a 0)
                  if (w_is_k) begin
                     r_state <= ST_SYNC;
                     r_zeros <= 3'd1;
                  end
               end

               ST_SYNC: begin
                  if (w_is_se0 || w_is_se1) begin
                     r_state <= ST_IDLE;
                  end else if (!w_bit) begin
                     if (r_zeros != 3'd7) begin
                        r_zeros <= r_zeros + 3'd1;
                     end
                  end else if (r_zeros >= c_sync_zeros) begin
                     r_state  <= ST_DATA;
                     r_sop    <= 1'b1;
                     r_active <= 1'b1;
                     // The SYNC-terminating 1 counts toward the stuff run
                     r_ones   <= 3'd1;
                     r_bitcnt <= 3'd0;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end

               ST_DATA: begin
                  // SE0 outranks the stuff check
                  if (w_is_se0) begin
                     r_state <= ST_EOP;
                  end else if (w_is_se1) begin
                     r_err       <= 1'b1;
                     r_active    <= 1'b0;
                     r_abort_se0 <= 1'b0;
                     r_state     <= ST_ABORT;
                  end else if (r_ones == c_stuff_len) begin
                     if (w_bit) begin
                        r_err       <= 1'b1;
                        r_active    <= 1'b0;
                        r_abort_se0 <= 1'b0;
                        r_state     <= ST_ABORT;
                     end else begin
                        r_ones <= 3'd0;
                     end
                  end else begin
                     r_shreg  <= w_shift;
                     r_bitcnt <= r_bitcnt + 3'd1;
                     r_ones   <= w_bit ? (r_ones + 3'd1) : 3'd0;
                     if (r_bitcnt == 3'd7) begin
                        r_data  <= w_shift;
                        r_valid <= 1'b1;
                     end
                  end
               end

               ST_EOP: begin
                  if (w_is_j) begin
                     r_eop    <= 1'b1;
                     r_active <= 1'b0;
                     r_state  <= ST_IDLE;
`ifdef USB_RX_ALIGN_CHECK_EN
                     r_err_align <= (r_bitcnt != 3'd0);
`endif
                  end else if (!w_is_se0) begin
                     r_err       <= 1'b1;
                     r_active    <= 1'b0;
                     r_abort_se0 <= 1'b0;
                     r_state     <= ST_ABORT;
                  end
               end

               ST_ABORT: begin
                  // Resynchronise on the bus's own SE0 -> J end of packet
                  if (w_is_se0) begin
                     r_abort_se0 <= 1'b1;
                  end else if (w_is_j && r_abort_se0) begin
                     r_abort_se0 <= 1'b0;
                     r_state     <= ST_IDLE;
                  end else begin
                     r_abort_se0 <= 1'b0;
                  end
               end

               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign o_data   = r_data;
   assign o_valid  = r_valid;
   assign o_sop    = r_sop;
   assign o_eop    = r_eop;
   assign o_active = r_active;
   assign o_err    = r_err;

`ifdef USB_RX_ALIGN_CHECK_EN
   assign o_err_align = r_err_align;
`else
   assign o_err_align = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_bitproc.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_rx_bitproc
// Description : Directed self-checking bench for usb_rx_bitproc. Drives NRZI
//               line symbols with sample strobes and compares framing, byte
//               and error pulses against hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_rx_bitproc;

   localparam logic [1:0] c_j   = 2'b10;
   localparam logic [1:0] c_k   = 2'b01;
   localparam logic [1:0] c_se0 = 2'b00;
   localparam logic [1:0] c_se1 = 2'b11;

`ifdef USB_RX_ALIGN_CHECK_EN
   localparam int c_align_exp = 1;
`else
   localparam int c_align_exp = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sample_en = 1'b0;
   logic       dp = 1'b1;
   logic       dn = 1'b0;
   logic [7:0] data;
   logic       valid, sop, eop, active, err, err_align;

   usb_rx_bitproc dut (
      .i_clk_4x    (clk),
      .i_rst_n     (rst_n),
      .i_sample_en (sample_en),
      .i_dp        (dp),
      .i_dn        (dn),
      .o_data      (data),
      .o_valid     (valid),
      .o_sop       (sop),
      .o_eop       (eop),
      .o_active    (active),
      .o_err       (err),
      .o_err_align (err_align)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- output monitor (samples on falling edge) ----------------
   int         sop_cnt = 0, valid_cnt = 0, eop_cnt = 0, err_cnt = 0;
   int         align_cnt = 0, both_cnt = 0, long_cnt = 0, glitch_cnt = 0;
   logic [7:0] rx_data [0:63];
   logic       p_valid = 1'b0, p_sop = 1'b0, p_eop = 1'b0, p_err = 1'b0, p_align = 1'b0;
   logic       in_pkt = 1'b0;

   always @(negedge clk) begin
      if (valid) begin
         if (valid_cnt < 64) rx_data[valid_cnt] = data;
         valid_cnt++;
      end
      if (sop)               sop_cnt++;
      if (eop)               eop_cnt++;
      if (err)               err_cnt++;
      if (err_align)         align_cnt++;
      if (eop && err_align)  both_cnt++;
      if ((valid && p_valid) || (sop && p_sop) || (eop && p_eop) ||
          (err && p_err) || (err_align && p_align))
         long_cnt++;
      p_valid = valid; p_sop = sop; p_eop = eop; p_err = err; p_align = err_align;
      if (!rst_n) begin
         in_pkt = 1'b0;
      end else begin
         if (in_pkt && !active && !eop && !err) glitch_cnt++;
         if (sop) in_pkt = 1'b1;
         if (eop || err) in_pkt = 1'b0;
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [1:0] tb_line = c_j;
   int         tb_ones = 0;
   int         gap = 3;
   int b_sop, b_valid, b_eop, b_err, b_align, b_both;

   task automatic snap();
      b_sop = sop_cnt; b_valid = valid_cnt; b_eop = eop_cnt;
      b_err = err_cnt; b_align = align_cnt; b_both = both_cnt;
   endtask

   task automatic send_sym(input logic [1:0] s);
      {dp, dn}  = s;
      sample_en = 1'b1;
      @(negedge clk);
      sample_en = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_raw(input logic b);
      if (!b) tb_line = (tb_line == c_j) ? c_k : c_j;
      send_sym(tb_line);
   endtask

   task automatic send_bit(input logic b, input logic stuff_en);
      send_raw(b);
      if (b) tb_ones++; else tb_ones = 0;
      if (stuff_en && tb_ones == 6) begin
         send_raw(1'b0);
         tb_ones = 0;
      end
   endtask

   task automatic send_sync();
      for (int i = 0; i < 7; i++) send_raw(1'b0);
      send_raw(1'b1);
      tb_ones = 1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stuff_en);
      for (int i = 0; i < 8; i++) send_bit(b[i], stuff_en);
   endtask

   task automatic send_eop();
      send_sym(c_se0);
      send_sym(c_se0);
      tb_line = c_j;
      send_sym(c_j);
   endtask

   task automatic idle(input int n);
      tb_line = c_j;
      repeat (n) send_sym(c_j);
   endtask

   task automatic settle();
      repeat (6) @(negedge clk);
   endtask

   // Full single-byte packet plus the standard framing checks
   task automatic packet_check(input string tag, input logic [7:0] b);
      snap();
      idle(3);
      send_sync();
      send_byte(b, 1'b1);
      send_eop();
      settle();
      check({tag, "_sop"},   sop_cnt - b_sop, 1);
      check({tag, "_valid"}, valid_cnt - b_valid, 1);
      check({tag, "_data"},  32'(rx_data[b_valid]), 32'(b));
      check({tag, "_eop"},   eop_cnt - b_eop, 1);
      check({tag, "_err"},   err_cnt - b_err, 0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- test sequence ----------------
   initial begin
      repeat (3) @(negedge clk);
      check("rst_data",   32'(data), 0);
      check("rst_valid",  32'(valid), 0);
      check("rst_active", 32'(active), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_sop",   32'(sop), 0);
      check("idle_eop",   32'(eop), 0);
      check("idle_err",   32'(err), 0);
      check("idle_align", 32'(err_align), 0);

      // Basic packet 0xA5, also checking o_active across the body
      snap();
      idle(3);
      send_sync();
      send_byte(8'hA5, 1'b1);
      settle();
      check("a5_active_mid", 32'(active), 1);
      send_eop();
      settle();
      check("a5_sop",   sop_cnt - b_sop, 1);
      check("a5_valid", valid_cnt - b_valid, 1);
      check("a5_data",  32'(rx_data[b_valid]), 32'h0000_00A5);
      check("a5_eop",   eop_cnt - b_eop, 1);
      check("a5_err",   err_cnt - b_err, 0);
      check("a5_active_end", 32'(active), 0);

      // 0xFF then 0x01: a stuffed 0 follows the 6th consecutive 1
      snap();
      idle(3);
      send_sync();
      send_byte(8'hFF, 1'b1);
      send_byte(8'h01, 1'b1);
      send_eop();
      settle();
      check("stuff_valid", valid_cnt - b_valid, 2);
      check("stuff_d0",    32'(rx_data[b_valid]), 32'h0000_00FF);
      check("stuff_d1",    32'(rx_data[b_valid + 1]), 32'h0000_0001);
      check("stuff_eop",   eop_cnt - b_eop, 1);
      check("stuff_err",   err_cnt - b_err, 0);
      check("stuff_align", align_cnt - b_align, 0);

      // Seven 1s in a row (SYNC's 1 + six data 1s unstuffed) -> stuff error
      snap();
      idle(3);
      send_sync();
      for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
      settle();
      check("serr_err",    err_cnt - b_err, 1);
      check("serr_active", 32'(active), 0);
      send_byte(8'h00, 1'b0);
      send_eop();
      settle();
      check("serr_valid", valid_cnt - b_valid, 0);
      check("serr_eop",   eop_cnt - b_eop, 0);
      packet_check("serr_next", 8'h96);

      // Short SYNC: three 0s then a 1 must not start a packet
      snap();
      idle(3);
      for (int i = 0; i < 3; i++) send_raw(1'b0);
      send_raw(1'b1);
      settle();
      check("short_sop",    sop_cnt - b_sop, 0);
      check("short_active", 32'(active), 0);
      packet_check("short_next", 8'h3C);

      // Asynchronous reset in the middle of the second byte
      snap();
      idle(3);
      send_sync();
      send_byte(8'hA5, 1'b1);
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b1);
      settle();
      check("arst_pre_data",   32'(data), 32'h0000_00A5);
      check("arst_pre_active", 32'(active), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_data",   32'(data), 0);
      check("arst_active", 32'(active), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      tb_ones = 0;
      settle();
      check("arst_eop", eop_cnt - b_eop, 0);
      check("arst_err", err_cnt - b_err, 0);
      packet_check("arst_next", 8'h5A);

      // 12 data bits then EOP: partial byte at end of packet
      snap();
      idle(3);
      send_sync();
      send_byte(8'hA5, 1'b1);
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b1);
      send_eop();
      settle();
      check("align_valid", valid_cnt - b_valid, 1);
      check("align_eop",   eop_cnt - b_eop, 1);
      check("align_pulse", align_cnt - b_align, c_align_exp);
      check("align_same",  both_cnt - b_both, c_align_exp);
      check("align_err",   err_cnt - b_err, 0);

      // Back-to-back strobes
      gap = 0;
      snap();
      idle(2);
      send_sync();
      send_byte(8'h3C, 1'b1);
      send_byte(8'hC3, 1'b1);
      send_eop();
      gap = 3;
      settle();
      check("b2b_valid", valid_cnt - b_valid, 2);
      check("b2b_d0",    32'(rx_data[b_valid]), 32'h0000_003C);
      check("b2b_d1",    32'(rx_data[b_valid + 1]), 32'h0000_00C3);
      check("b2b_eop",   eop_cnt - b_eop, 1);

      // SE1 inside a packet
      snap();
      idle(3);
      send_sync();
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b1);
      send_sym(c_se1);
      settle();
      check("se1_err",    err_cnt - b_err, 1);
      check("se1_active", 32'(active), 0);
      send_eop();
      settle();
      check("se1_eop",   eop_cnt - b_eop, 0);
      check("se1_valid", valid_cnt - b_valid, 0);
      packet_check("se1_next", 8'h81);

      check("pulse_width",  long_cnt, 0);
      check("active_holds", glitch_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
